result_drain_2x2: RTL and testbench
===================================

// Module: result_drain_2x2
// PURPOSE
//  Output stage directly downstream of the 2x2 systolic array. On a start pulse it
//  snapshots the four signed accumulator outputs (c00,c01,c10,c11). It either
//  requantizes them to int8 with round and saturate, or passes them through as raw
//  16-bit words. It then streams the result bytes to the writeback/memory side over a
//  valid/ready byte interface, which lets the array be cleared and reloaded while draining.
// PARAMETERS
//  ACC_W    16  width of each signed accumulator input
//  OUT_W     8  width of the output byte stream (fixed at 8; ACC_W must equal 2*OUT_W)
//  SHIFT_W   4  width of the requantization shift amount
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  rst        in   1        asynchronous reset, active-low
//  start      in   1        capture request; accepted only in IDLE
//  quant      in   1        sampled at accept: 1 = int8 requant (4 beats), 0 = raw 16-bit (8 beats)
//  shift      in   SHIFT_W  sampled at accept: arithmetic right-shift amount (0..15)
//  c00..c11   in   ACC_W    signed array results, sampled at accept
//  out_data   out  OUT_W    current byte
//  out_valid  out  1        out_data is valid
//  out_ready  in   1        consumer accepts the byte when out_valid && out_ready
//  busy       out  1        high while in SEND
//  done       out  1        one-cycle pulse after the last beat is accepted
//  overflow   out  1        at least one value saturated in the current/last transaction
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, beat index=0, all outputs 0. Effect is immediate,
//   including mid-SEND; any in-flight transaction is discarded and is not resumed.
//  FSM: IDLE --start--> SEND --last beat handshake--> IDLE.
//  Accept: start=1 in IDLE at edge N latches all four results (processed), quant and
//   shift, and clears beat index. At N+1: busy=1, out_valid=1, first byte on out_data.
//  start is ignored while busy, including the cycle of the final handshake. There is
//   no queueing.
//  Requant (quant=1), per value v, computed once at accept in ACC_W+1 bits:
//   r = (shift==0) ? v : (v + (1<<(shift-1))) >>> shift   (round half up, floor shift)
//   out = sat to [-128,127]; overflow = OR of all four saturations.
//   overflow is cleared on accept and held until the next accept.
//  Raw (quant=0): overflow stays 0.
//  Beat order: quant=1 gives c00,c01,c10,c11 (4 beats). quant=0 gives c00[7:0],c00[15:8],
//   c01 lo,hi, c10 lo,hi, c11 lo,hi (8 beats, little-endian).
//  Handshake: a beat advances only on out_valid&&out_ready. out_data must stay stable
//   while out_valid&&!out_ready. out_valid never drops mid-transaction except on reset.
//   Back-to-back beats at full rate when out_ready=1.
//  Completion: when the last beat is accepted at edge M, the FSM enters IDLE. From M+1,
//   out_valid=0 and busy=0, done=1 for exactly one cycle, and out_data returns to 0.
//  Latency: with out_ready=1 the block completes in quant?4:8 cycles after accept.
//   The earliest next accept is the cycle after done rises.
//  Inputs c00..c11 may change freely after accept; only the snapshot is streamed.
// TESTING
//  1. quant=1, shift=0, c=5,-3,127,-128, out_ready=1 -> bytes 05,FD,7F,80 on 4 consecutive
//     cycles; done pulse the next cycle; overflow=0.
//  2. quant=1, shift=4, c=296,-300,32767,-32768 -> bytes 13,ED,7F,80; overflow=1.
//  3. quant=0, c00=16'h1234, c01=16'hABCD, c10=16'h0001, c11=16'h8000 -> bytes
//     34,12,CD,AB,01,00,00,80; overflow=0.
//  4. Backpressure: out_ready=0 for 3 cycles on beat 2 of test 1 -> out_data held at FD,
//     out_valid stays 1, no beat skipped or duplicated; done is delayed by 3 cycles.
//  5. start pulsed mid-SEND, and again in the final handshake cycle -> both ignored, no
//     re-capture; a start on the cycle done=1 is accepted.
//  6. rst low during beat 3 -> out_valid, busy, done, overflow go to 0 without waiting
//     for a clock edge; after release a new start streams a fresh snapshot from beat 0.

Source files
------------

// File: rtl/result_drain_2x2.sv
// result_drain_2x2
//   Output stage behind the 2x2 systolic array. A start pulse accepted in IDLE
//   snapshots the four signed accumulators. Each value is either requantized to
//   int8 (round half up, arithmetic shift, saturate) or kept as a raw 16-bit word.
//   The result bytes are then streamed over a valid/ready byte interface. The
//   array can be cleared and reloaded while the snapshot drains.
//
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   start      in   capture request, honoured only in IDLE
//   quant      in   1: int8 requant (4 beats), 0: raw little-endian (8 beats)
//   shift      in   requant arithmetic right-shift amount
//   c00..c11   in   signed accumulator results, sampled at accept
//   out_data   out  current byte
//   out_valid  out  out_data is valid
//   out_ready  in   consumer takes the byte on out_valid && out_ready
//   busy       out  high while streaming
//   done       out  one-cycle pulse after the last beat is taken
//   overflow   out  a value saturated in the current/last transaction
module result_drain_2x2 #(
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               quant,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [ACC_W-1:0]   c00,
  input  logic [ACC_W-1:0]   c01,
  input  logic [ACC_W-1:0]   c10,
  input  logic [ACC_W-1:0]   c11,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

  // Returns {saturated, byte}. Math is done one bit wider than the input so
  // the rounding add cannot wrap.
  function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0]   v,
                                             input logic [SHIFT_W-1:0] sh);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    ext = $signed({v[ACC_W-1], v});
    if (sh == '0) begin
      r = ext;
    end else begin
      rnd = ext + $signed((ACC_W+1)'(1) << (sh - SHIFT_W'(1)));
      r   = rnd >>> sh;
    end
    if (r > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (r < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  state_t           state_q,     state_d;
  logic [2:0]       beat_q,      beat_d;
  logic             quant_q,     quant_d;
  logic [OUT_W-1:0] buf_q [8];
  logic [OUT_W-1:0] buf_d [8];
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             overflow_q,  overflow_d;
  logic [OUT_W:0]   rq [4];
  logic [2:0]       last_beat;

  assign last_beat = quant_q ? 3'd3 : 3'd7;

  always_comb begin
    rq[0] = requant(c00, shift);
    rq[1] = requant(c01, shift);
    rq[2] = requant(c10, shift);
    rq[3] = requant(c11, shift);

    state_d     = state_q;
    beat_d      = beat_q;
    quant_d     = quant_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        out_data_d  = '0;
        if (start) begin
          state_d     = SEND;
          beat_d      = '0;
          quant_d     = quant;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          if (quant) begin
            for (int unsigned i = 0; i < 4; i++) begin
              buf_d[i] = rq[i][OUT_W-1:0];
            end
            overflow_d = rq[0][OUT_W] | rq[1][OUT_W] | rq[2][OUT_W] | rq[3][OUT_W];
          end else begin
            buf_d[0]   = c00[OUT_W-1:0];
            buf_d[1]   = c00[ACC_W-1:OUT_W];
            buf_d[2]   = c01[OUT_W-1:0];
            buf_d[3]   = c01[ACC_W-1:OUT_W];
            buf_d[4]   = c10[OUT_W-1:0];
            buf_d[5]   = c10[ACC_W-1:OUT_W];
            buf_d[6]   = c11[OUT_W-1:0];
            buf_d[7]   = c11[ACC_W-1:OUT_W];
            overflow_d = 1'b0;
          end
          // First byte is presented straight from the freshly built snapshot
          // so it is valid in the cycle right after accept.
          out_data_d = buf_d[0];
        end
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          if (beat_q == last_beat) begin
            state_d     = IDLE;
            beat_d      = '0;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
          end else begin
            beat_d     = beat_q + 3'd1;
            out_data_d = buf_q[beat_q + 3'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      quant_q     <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        buf_q[i] <= '0;
      end
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      quant_q     <= quant_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_drain_2x2.sv
// Testbench for result_drain_2x2: directed cases plus randomized transactions,
// all checked against a behavioural model of the byte stream.
module tb_result_drain_2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        quant;
  logic [3:0]  shift;
  logic [15:0] c00, c01, c10, c11;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  result_drain_2x2 #(.ACC_W(16), .OUT_W(8), .SHIFT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .quant     (quant),
    .shift     (shift),
    .c00       (c00),
    .c01       (c01),
    .c10       (c10),
    .c11       (c11),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    c00   = 16'($urandom);
    c01   = 16'($urandom);
    c10   = 16'($urandom);
    c11   = 16'($urandom);
    quant = 1'($urandom);
    shift = 4'($urandom);
  endtask

  // ready_mode 0: ready high except the optional stall window; 1: random ready.
  // rst_beat >= 0 asserts reset while that beat is on the bus.
  task automatic run_txn(input bit q, input logic [3:0] sh,
                         input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3,
                         input int ready_mode, input int stall_beat, input int stall_len,
                         input bit poke_start, input int rst_beat, input bit b2b);
    logic [15:0] vs [4];
    logic [7:0]  exp_b [$];
    bit          exp_ovf;
    int          n, idx, cyc, stalled, v, r, shi;
    bit          rdy;

    vs[0] = v0; vs[1] = v1; vs[2] = v2; vs[3] = v3;
    exp_ovf = 1'b0;
    shi = int'(sh);
    for (int k = 0; k < 4; k++) begin
      v = int'($signed(vs[k]));
      if (q) begin
        r = (shi == 0) ? v : ((v + (1 << (shi - 1))) >>> shi);
        if (r > 127)  begin r = 127;  exp_ovf = 1'b1; end
        if (r < -128) begin r = -128; exp_ovf = 1'b1; end
        exp_b.push_back(r[7:0]);
      end else begin
        exp_b.push_back(vs[k][7:0]);
        exp_b.push_back(vs[k][15:8]);
      end
    end
    n = exp_b.size();

    quant = q; shift = sh;
    c00 = v0; c01 = v1; c10 = v2; c11 = v3;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
    chk("ovf_at_first_beat", overflow, exp_ovf);

    idx = 0; cyc = 0; stalled = 0;
    while (idx < n && cyc < 100) begin
      chk("busy_send", busy, 1);
      chk("valid_send", out_valid, 1);
      chk("done_send", done, 0);
      chk($sformatf("beat%0d", idx), out_data, exp_b[idx]);
      if (idx == rst_beat) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_done", done, 0);
        chk("rst_async_ovf", overflow, 0);
        chk("rst_async_data", out_data, 0);
        out_ready = 1'b1;
        tick();
        chk("rst_hold_valid", out_valid, 0);
        rst = 1'b1;
        return;
      end
      rdy = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (idx == stall_beat && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      out_ready = rdy;
      if (poke_start && (idx == 1 || (idx == n - 1 && rdy))) begin
        scramble_inputs();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (rdy) idx++;
    end
    start = 1'b0;

    chk("complete", idx, n);
    if (ready_mode == 0) chk("latency", cyc, n + stall_len);
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", out_valid, 0);
    chk("data_after", out_data, 0);
    chk("ovf_after", overflow, exp_ovf);
    if (!b2b) begin
      out_ready = 1'($urandom);
      tick();
      chk("done_one_cycle", done, 0);
      chk("busy_idle", busy, 0);
      chk("valid_idle", out_valid, 0);
      chk("ovf_held", overflow, exp_ovf);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; quant = 1'b0; shift = '0;
    c00 = '0; c01 = '0; c10 = '0; c11 = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_data", out_data, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();

    // requant, shift 0, no saturation
    run_txn(1'b1, 4'd0, 16'd5, 16'hFFFD, 16'd127, 16'hFF80, 0, -1, 0, 1'b0, -1, 1'b0);
    // requant with rounding and saturation
    run_txn(1'b1, 4'd4, 16'd296, 16'hFED4, 16'h7FFF, 16'h8000, 0, -1, 0, 1'b0, -1, 1'b0);
    // raw little-endian
    run_txn(1'b0, 4'd9, 16'h1234, 16'hABCD, 16'h0001, 16'h8000, 0, -1, 0, 1'b0, -1, 1'b0);
    // 3-cycle stall on beat 2
    run_txn(1'b1, 4'd0, 16'd5, 16'hFFFD, 16'd127, 16'hFF80, 0, 1, 3, 1'b0, -1, 1'b0);
    // start while busy and on the final handshake ignored; start on done accepted
    run_txn(1'b1, 4'd0, 16'd5, 16'hFFFD, 16'd127, 16'hFF80, 0, -1, 0, 1'b1, -1, 1'b1);
    run_txn(1'b0, 4'd0, 16'h1234, 16'hABCD, 16'h0001, 16'h8000, 0, -1, 0, 1'b0, -1, 1'b0);
    // async reset during beat 3, then a fresh snapshot
    run_txn(1'b1, 4'd4, 16'd296, 16'hFED4, 16'h7FFF, 16'h8000, 0, -1, 0, 1'b0, 2, 1'b0);
    run_txn(1'b0, 4'd0, 16'h1234, 16'hABCD, 16'h0001, 16'h8000, 0, -1, 0, 1'b0, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] rv [4];
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) != 0) rv[k] = 16'($urandom_range(0, 511) - 256);
        else                           rv[k] = 16'($urandom);
      end
      run_txn(1'($urandom), 4'($urandom), rv[0], rv[1], rv[2], rv[3], 1, -1, 0,
              1'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
              1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
